fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that shares one `sync_fifo` write port between `NUM_REQ` independent producers. Each producer has a valid/ready handshake; the arbiter grants one producer at a time for a bounded burst and muxes its data onto the FIFO write port. It backpressures on FIFO `full` and checks every issued write against the FIFO's `write_ack`. It sits directly in front of the FIFO instance. Its FIFO-facing outputs connect straight to the FIFO's `write_enable`/`data_in`, and its FIFO-facing inputs connect to the FIFO's `full`/`write_ack`.

## Interface
- `NUM_REQ`, 4: number of producers (2..16).
- `DATA_WIDTH`, 16: data width; must match the FIFO.
- `MAX_BURST`, 4: maximum consecutive beats per grant (1..256).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in `NUM_REQ`: producer i has a beat on `req_data[i]`.
- `req_data` in `NUM_REQ*DATA_WIDTH`: producer i data at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `NUM_REQ`: beat from producer i accepted this cycle when valid&ready.
- `fifo_full` in 1: FIFO full flag.
- `fifo_write_ack` in 1: FIFO write acknowledge (one cycle after a successful write).
- `fifo_write_enable` out 1: FIFO write strobe.
- `fifo_data_in` out `DATA_WIDTH`: FIFO write data.
- `grant_valid` out 1: a producer currently holds the grant.
- `grant_id` out `$clog2(NUM_REQ)`: index of the granted producer.
- `beats_written` out 16: total accepted beats; wraps 0xFFFF→0.
- `ack_err` out 1: sticky; a write was issued without `fifo_write_ack` the next cycle.

## Operation
- State machine:
  - IDLE: `grant_valid=0`. If any `req_valid`, select the first valid index searching upward from `rr_ptr`, modulo `NUM_REQ`. Register that index into `grant_id`, clear `beat_cnt`, and go to BURST. Otherwise stay in IDLE.
  - BURST: `grant_valid=1`.
- Transfer condition: `xfer = state==BURST & req_valid[grant_id] & !fifo_full`.
- `req_ready[i] = (state==BURST) & (i==grant_id) & !fifo_full`, combinational. Non-granted producers always see `ready=0`.
- `fifo_write_enable = xfer`. `fifo_data_in = req_data[grant_id]`, combinational mux. `fifo_data_in` is don't-care when `xfer=0`, but is driven 0 in IDLE.
- On `xfer`:
  - `beat_cnt` increments and `beats_written` increments.
  - If `beat_cnt==MAX_BURST-1`, release.
- If `req_valid[grant_id]==0` in BURST, release (no transfer that cycle).
- `fifo_full` with valid high: hold the grant. No counting, no release, no timeout.
- Release: go to IDLE, set `rr_ptr = (grant_id+1) mod NUM_REQ`. The released producer gets lowest priority in the next arbitration.
- Ack check: register `wr_pend <= xfer`. If `wr_pend & !fifo_write_ack`, set `ack_err`. It clears only on `rst`.
- Arithmetic: `beat_cnt` is `$clog2(MAX_BURST+1)` bits. `rr_ptr` and `grant_id` wrap modulo `NUM_REQ`, which need not be a power of 2.

## Timing
- Reset values (async on `rst`):
  - state IDLE.
  - `rr_ptr`, `grant_id`, `beat_cnt`, `beats_written`, `wr_pend`, `ack_err` all 0.
  - `grant_valid=0`, `req_ready=0`, `fifo_write_enable=0`, `fifo_data_in=0`.
- Arbitration latency: one IDLE cycle between grants. A valid request seen in cycle N can transfer earliest in cycle N+1.
- Burst throughput: one beat per cycle while valid and `!fifo_full`.
- Maximum sustained rate with all producers busy: `MAX_BURST` beats per `MAX_BURST+1` cycles.
- `fifo_full` takes effect in the same cycle. The FIFO's `full` reflects its registered count, so no write is ever issued to a full FIFO.
- Reset mid-burst: the grant is dropped immediately and outputs go to reset values. A beat in flight that cycle is not counted. `wr_pend` is cleared, so no false `ack_err`.
- A producer deasserting valid at the exact cycle its last burst beat completes releases only once.
- A lone requester is re-granted after one IDLE cycle.

## Test plan
- **Basic burst.** `NUM_REQ=4`, `MAX_BURST=4`. Producer 0 streams 0x1000..0x1007 continuously, others idle, FIFO never full. Expect:
  - Beats 0x1000..0x1003 in 4 consecutive cycles, then 1 IDLE cycle, then 0x1004..0x1007.
  - `beats_written=8`; `ack_err=0`.
- **Round-robin.** All 4 producers valid continuously. Expect:
  - `grant_id` sequence 0,1,2,3,0 with 4 beats each.
  - Each producer's data appears in its own order; no starvation.
- **Backpressure.** Producer 2 granted, `fifo_full` high for 3 cycles mid-burst. Expect:
  - `req_ready[2]=0` and `fifo_write_enable=0` for those 3 cycles.
  - The burst resumes and completes exactly 4 beats.
- **Early release.** Producer 1 drops valid after 2 beats while producer 3 is valid. Expect:
  - Release, then an IDLE cycle, then `grant_id=3`, then `rr_ptr=2` after that release.
- **Ack error.** Force `fifo_write_ack=0` the cycle after a write. Expect `ack_err=1` next cycle, held until `rst` pulses.
- **Reset and wrap.** Assert `rst` mid-burst: all outputs go to reset values within the same cycle. Preload to 0xFFFF accepted beats, then 1 more: `beats_written` wraps to 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signal bundle for fifo_wr_arbiter.
// The arbiter uses the slave modport; the environment driving producers and the FIFO uses master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_write_ack;
  logic                          fifo_write_enable;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          grant_valid;
  logic [ID_W-1:0]               grant_id;
  logic [15:0]                   beats_written;
  logic                          ack_err;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_write_ack,
    output req_ready, fifo_write_enable, fifo_data_in, grant_valid, grant_id,
           beats_written, ack_err
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_write_ack,
    input  req_ready, fifo_write_enable, fifo_data_in, grant_valid, grant_id,
           beats_written, ack_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among NUM_REQ producers,
// with full backpressure and a sticky check that every write is acknowledged.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);
  // state | meaning
  // IDLE  | no grant; arbitrate among valid producers starting at rr_ptr
  // BURST | grant held; stream beats until MAX_BURST, valid drop, or reset
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [15:0]       beats_written_q, beats_written_d;
  logic              wr_pend_q, wr_pend_d;
  logic              ack_err_q, ack_err_d;

  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   next_ptr;
  logic              pick_found;
  int                pick_idx;
  logic              gnt_valid;
  logic              xfer;

  // Modulo wrap done by subtraction so non-power-of-2 NUM_REQ works.
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    pick_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pick_idx = int'(rr_ptr_q) + k;
      if (pick_idx >= NUM_REQ) pick_idx = pick_idx - NUM_REQ;
      if (!pick_found && bus.req_valid[pick_idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(pick_idx);
      end
    end
  end

  assign gnt_valid = bus.req_valid[grant_id_q];
  assign next_ptr  = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + ID_W'(1);
  assign xfer      = (state_q == S_BURST) && gnt_valid && !bus.fifo_full;

  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_id_d      = grant_id_q;
    beat_cnt_d      = beat_cnt_q;
    beats_written_d = beats_written_q + {15'd0, xfer};
    wr_pend_d       = xfer;
    ack_err_d       = ack_err_q | (wr_pend_q & ~bus.fifo_write_ack);
    if (state_q == S_IDLE) begin
      if (pick_found) begin
        grant_id_d = pick_id;
        beat_cnt_d = '0;
        state_d    = S_BURST;
      end
    end else begin
      if (!gnt_valid) begin
        state_d  = S_IDLE;
        rr_ptr_d = next_ptr;
      end else if (!bus.fifo_full) begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
        if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
    end
  end

  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_data_in = '0;
    if (state_q == S_BURST) begin
      bus.fifo_data_in = bus.req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
      for (int i = 0; i < NUM_REQ; i++)
        bus.req_ready[i] = (i == int'(grant_id_q)) && !bus.fifo_full;
    end
  end

  assign bus.fifo_write_enable = xfer;
  assign bus.grant_valid       = (state_q == S_BURST);
  assign bus.grant_id          = grant_id_q;
  assign bus.beats_written     = beats_written_q;
  assign bus.ack_err           = ack_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      grant_id_q      <= '0;
      beat_cnt_q      <= '0;
      beats_written_q <= '0;
      wr_pend_q       <= 1'b0;
      ack_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_id_q      <= grant_id_d;
      beat_cnt_q      <= beat_cnt_d;
      beats_written_q <= beats_written_d;
      wr_pend_q       <= wr_pend_d;
      ack_err_q       <= ack_err_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scenario and randomized checks of fifo_wr_arbiter against a producer/grant-level model;
// a second instance (3 producers, 256-beat bursts) covers beats_written wrap.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(DW)) bus2 ();
  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .MAX_BURST(256)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  logic [N-1:0]  valid;
  logic [DW-1:0] pdata [N];
  logic          full;
  logic          ack;
  logic          ack_kill;
  logic [2:0]    valid2;

  assign bus.req_valid      = valid;
  assign bus.fifo_full      = full;
  assign bus.fifo_write_ack = ack;
  always_comb begin
    bus.req_data = '0;
    for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = pdata[i];
  end

  assign bus2.req_valid      = valid2;
  assign bus2.req_data       = {16'hC002, 16'hC001, 16'hC000};
  assign bus2.fifo_full      = 1'b0;
  assign bus2.fifo_write_ack = 1'b1;

  int n_pass;
  int n_checks;

  // Model: who owns the port, how many beats it has used, and who has priority next.
  int          m_owner;
  int          m_next;
  int          m_beats;
  logic [1:0]  m_gid;
  logic [15:0] m_count;
  logic        m_pend;
  logic        m_err;
  logic          e_gv;
  logic [N-1:0]  e_ready;
  logic          e_we;
  logic [DW-1:0] e_data;

  task automatic model_eval();
    e_gv = 1'b0; e_ready = '0; e_we = 1'b0; e_data = '0;
    if (m_owner >= 0) begin
      e_gv   = 1'b1;
      if (!full) e_ready[m_owner] = 1'b1;
      e_we   = valid[m_owner] && !full;
      e_data = pdata[m_owner];
    end
  endtask

  task automatic model_update();
    int c;
    bit found;
    m_err  = m_err | (m_pend & ~ack);
    m_pend = e_we;
    if (m_owner < 0) begin
      if (valid != '0) begin
        found = 0;
        c = 0;
        for (int k = 0; k < N; k++)
          if (!found && valid[(m_next + k) % N]) begin found = 1; c = (m_next + k) % N; end
        m_owner = c; m_gid = 2'(c); m_beats = 0;
      end
    end else if (!valid[m_owner]) begin
      m_next = (m_owner + 1) % N; m_owner = -1;
    end else if (!full) begin
      pdata[m_owner] = pdata[m_owner] + 16'd1;
      m_beats = m_beats + 1;
      m_count = m_count + 16'd1;
      if (m_beats == MB) begin m_next = (m_owner + 1) % N; m_owner = -1; end
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_next = 0; m_beats = 0; m_gid = 0; m_count = 0; m_pend = 0; m_err = 0;
  endtask

  task automatic advance();
    logic we_s;
    model_eval();
    we_s = e_we;
    @(posedge clk); #1;
    model_update();
    ack = we_s & ~ack_kill;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; full = 1'b0; ack = 1'b0; ack_kill = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    valid = '1; full = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.grant_valid !== 1'b0) $display("FAIL reset_gv got=%b exp=0", bus.grant_valid); else n_pass++;
    n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.fifo_write_enable !== 1'b0) $display("FAIL reset_we got=%b exp=0", bus.fifo_write_enable); else n_pass++;
    n_checks++; if (bus.fifo_data_in !== 16'h0) $display("FAIL reset_data got=%h exp=0000", bus.fifo_data_in); else n_pass++;
    n_checks++; if (bus.grant_id !== 2'd0) $display("FAIL reset_gid got=%0d exp=0", bus.grant_id); else n_pass++;
    n_checks++; if (bus.beats_written !== 16'h0) $display("FAIL reset_beats got=%h exp=0000", bus.beats_written); else n_pass++;
    n_checks++; if (bus.ack_err !== 1'b0) $display("FAIL reset_ack_err got=%b exp=0", bus.ack_err); else n_pass++;
  endtask

  task automatic test_basic_burst();
    logic          exp_we;
    logic [15:0]   exp_d;
    do_reset();
    pdata[0] = 16'h1000; valid = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_we = !(c == 0 || c == 5);
      exp_d  = 16'h1000 + 16'((c < 5) ? c - 1 : c - 2);
      n_checks++;
      if (bus.fifo_write_enable !== exp_we) $display("FAIL basic_we cyc=%0d got=%b exp=%b", c, bus.fifo_write_enable, exp_we); else n_pass++;
      if (exp_we) begin
        n_checks++;
        if (bus.fifo_data_in !== exp_d) $display("FAIL basic_data cyc=%0d got=%h exp=%h", c, bus.fifo_data_in, exp_d); else n_pass++;
      end
      advance();
    end
    valid = '0;
    @(negedge clk);
    n_checks++; if (bus.beats_written !== 16'd8) $display("FAIL basic_beats got=%0d exp=8", bus.beats_written); else n_pass++;
    n_checks++; if (bus.ack_err !== 1'b0) $display("FAIL basic_ack_err got=%b exp=0", bus.ack_err); else n_pass++;
    n_checks++; if (bus.grant_valid !== 1'b0) $display("FAIL basic_release got=%b exp=0", bus.grant_valid); else n_pass++;
  endtask

  task automatic test_round_robin();
    int g, k;
    logic [19:0] got, exp;
    do_reset();
    for (int i = 0; i < N; i++) pdata[i] = 16'h2000 + 16'(i * 256);
    valid = '1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      g = (c / 5) % 4;
      k = (c / 20) * 4 + (c % 5) - 1;
      n_checks++;
      if (c % 5 == 0) begin
        if ({bus.grant_valid, bus.fifo_write_enable} !== 2'b00)
          $display("FAIL rr_idle cyc=%0d got gv=%b we=%b exp gv=0 we=0", c, bus.grant_valid, bus.fifo_write_enable);
        else n_pass++;
      end else begin
        got = {bus.grant_valid, bus.grant_id, bus.fifo_write_enable, bus.fifo_data_in};
        exp = {1'b1, 2'(g), 1'b1, 16'h2000 + 16'(g * 256 + k)};
        if (got !== exp) $display("FAIL rr_beat cyc=%0d got=%h exp=%h", c, got, exp); else n_pass++;
      end
      advance();
    end
    @(negedge clk);
    n_checks++; if (bus.beats_written !== 16'd20) $display("FAIL rr_beats got=%0d exp=20", bus.beats_written); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0]  got, exp;
    logic [15:0] exp_d;
    do_reset();
    pdata[2] = 16'h3000; valid = 4'b0100;
    for (int c = 0; c < 9; c++) begin
      full = (c >= 3 && c <= 5);
      @(negedge clk);
      exp_d = 16'h3000;
      case (c)
        1, 2:    begin exp = {1'b1, 2'd2, 4'b0100, 1'b1}; exp_d = 16'h3000 + 16'(c - 1); end
        3, 4, 5: exp = {1'b1, 2'd2, 4'b0000, 1'b0};
        6, 7:    begin exp = {1'b1, 2'd2, 4'b0100, 1'b1}; exp_d = 16'h3000 + 16'(c - 4); end
        default: exp = {1'b0, bus.grant_id, 4'b0000, 1'b0};
      endcase
      got = {bus.grant_valid, bus.grant_id, bus.req_ready, bus.fifo_write_enable};
      n_checks++;
      if (got !== exp) $display("FAIL bp_ctrl cyc=%0d got=%b exp=%b", c, got, exp); else n_pass++;
      if (exp[0]) begin
        n_checks++;
        if (bus.fifo_data_in !== exp_d) $display("FAIL bp_data cyc=%0d got=%h exp=%h", c, bus.fifo_data_in, exp_d); else n_pass++;
      end
      if (c == 8) begin
        n_checks++;
        if (bus.beats_written !== 16'd4) $display("FAIL bp_beats got=%0d exp=4", bus.beats_written); else n_pass++;
      end
      advance();
    end
    full = 1'b0;
  endtask

  task automatic test_early_release();
    logic        exp_gv, exp_we;
    logic [1:0]  exp_gid;
    logic [15:0] exp_d;
    do_reset();
    pdata[0] = 16'h4100; pdata[1] = 16'h4000; pdata[3] = 16'h4300;
    valid = 4'b1010;
    for (int c = 0; c < 11; c++) begin
      if (c == 3) valid = 4'b1001;
      @(negedge clk);
      exp_gv = 1'b1; exp_we = 1'b1; exp_gid = 2'd1; exp_d = 16'h0;
      case (c)
        0, 4, 9:       begin exp_gv = 1'b0; exp_we = 1'b0; end
        1, 2:          exp_d = 16'h4000 + 16'(c - 1);
        3:             exp_we = 1'b0;
        5, 6, 7, 8:    begin exp_gid = 2'd3; exp_d = 16'h4300 + 16'(c - 5); end
        default:       begin exp_gid = 2'd0; exp_d = 16'h4100; end
      endcase
      n_checks++;
      if ({bus.grant_valid, bus.fifo_write_enable} !== {exp_gv, exp_we})
        $display("FAIL early_ctrl cyc=%0d got gv=%b we=%b exp gv=%b we=%b", c, bus.grant_valid, bus.fifo_write_enable, exp_gv, exp_we);
      else n_pass++;
      if (exp_gv) begin
        n_checks++;
        if (bus.grant_id !== exp_gid) $display("FAIL early_gid cyc=%0d got=%0d exp=%0d", c, bus.grant_id, exp_gid); else n_pass++;
      end
      if (exp_we) begin
        n_checks++;
        if (bus.fifo_data_in !== exp_d) $display("FAIL early_data cyc=%0d got=%h exp=%h", c, bus.fifo_data_in, exp_d); else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_ack_error();
    do_reset();
    pdata[0] = 16'h5000; valid = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        n_checks++;
        if (bus.ack_err !== (c >= 3)) $display("FAIL ack_err cyc=%0d got=%b exp=%b", c, bus.ack_err, (c >= 3)); else n_pass++;
      end
      ack_kill = (c == 1);
      advance();
    end
    ack_kill = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.ack_err !== 1'b0) $display("FAIL ack_err_clear got=%b exp=0", bus.ack_err); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    logic [40:0] got, exp;
    do_reset();
    pdata[0] = 16'h6000; valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if (bus.fifo_write_enable !== 1'b1) $display("FAIL rstmid_pre got=%b exp=1", bus.fifo_write_enable); else n_pass++;
      end else advance();
    end
    rst = 1'b1;
    #1;
    got = {bus.grant_valid, bus.grant_id, bus.req_ready, bus.fifo_write_enable, bus.fifo_data_in, bus.beats_written, bus.ack_err};
    n_checks++;
    if (got !== 41'd0) $display("FAIL rstmid_outputs got=%h exp=0", got); else n_pass++;
    model_reset();
    ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      model_eval();
      got = {bus.grant_valid, bus.grant_id, bus.req_ready, bus.fifo_write_enable, bus.fifo_data_in, bus.beats_written, bus.ack_err};
      exp = {e_gv, m_gid, e_ready, e_we, e_data, m_count, m_err};
      n_checks++;
      if (got !== exp) $display("FAIL rstmid_after cyc=%0d got=%h exp=%h", c, got, exp); else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    logic [40:0] got, exp;
    do_reset();
    for (int i = 0; i < N; i++) pdata[i] = 16'($urandom);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) valid[i] = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      model_eval();
      got = {bus.grant_valid, bus.grant_id, bus.req_ready, bus.fifo_write_enable, bus.fifo_data_in, bus.beats_written, bus.ack_err};
      exp = {e_gv, m_gid, e_ready, e_we, e_data, m_count, m_err};
      n_checks++;
      if (got !== exp) $display("FAIL random cyc=%0d got=%h exp=%h", c, got, exp); else n_pass++;
      advance();
    end
    valid = '0; full = 1'b0;
  endtask

  task automatic test_wrap();
    int  cnt, b, guard;
    bit  busy;
    rst = 1'b1; valid2 = 3'b010;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0; b = 0; busy = 0; guard = 0;
    for (int phase = 0; phase < 2; phase++) begin
      while (cnt < 65535 + phase && guard < 70000) begin
        @(posedge clk);
        guard++;
        if (!busy) begin busy = 1; b = 0; end
        else begin
          b++; cnt++;
          if (b == 256) busy = 0;
        end
      end
      @(negedge clk);
      n_checks++;
      if (guard >= 70000) $display("FAIL wrap_timeout phase=%0d beats_seen=%0d", phase, cnt);
      else if (bus2.beats_written !== ((phase == 0) ? 16'hFFFF : 16'h0000))
        $display("FAIL wrap_beats phase=%0d got=%h exp=%h", phase, bus2.beats_written, (phase == 0) ? 16'hFFFF : 16'h0000);
      else n_pass++;
    end
    n_checks++;
    if (bus2.grant_id !== 2'd1) $display("FAIL wrap_gid got=%0d exp=1", bus2.grant_id); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_checks = 0;
    valid = '0; full = 1'b0; ack = 1'b0; ack_kill = 1'b0; valid2 = '0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    model_reset();
    test_reset();
    test_basic_burst();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_ack_error();
    test_reset_mid_burst();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
